// File: rtl/rom_sched_pkg.sv
// Shared types and constants for the ROM read scheduler.
package rom_sched_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StData,
    StDrainAddr,
    StDrainData
  } state_e;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rom_read_scheduler_if.sv
// AXI-Lite read-only channel bundle (AR/R) between scheduler and ROM target.
interface rom_read_scheduler_if #(
  parameter int unsigned AXI_ADDR_WIDTH = 16,
  parameter int unsigned AXI_DATA_WIDTH = 32
) ();

  logic [AXI_ADDR_WIDTH-1:0] araddr;
  logic [2:0]                arprot;
  logic                      arvalid;
  logic                      arready;
  logic [AXI_DATA_WIDTH-1:0] rdata;
  logic [1:0]                rresp;
  logic                      rvalid;
  logic                      rready;

  modport master (
    output araddr, arprot, arvalid, rready,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  araddr, arprot, arvalid, rready,
    output arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/rom_read_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or above ptr_i, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IdxW    = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IdxW-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IdxW-1:0]    idx_o
);

  logic        found;
  int unsigned j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      j = (32'(ptr_i) + i) % NUM_REQ;
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IdxW'(j);
      end
    end
  end

endmodule

// File: rtl/rom_read_scheduler.sv
// Round-robin scheduler sharing one AXI-Lite read port among NUM_REQ requesters,
// one read outstanding, with a per-read timeout and silent drain of late transactions.
module rom_read_scheduler
  import rom_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned AXI_ADDR_WIDTH = 16,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                              s_axi_clk,
  input  logic                              s_axi_rstn,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic [NUM_REQ-1:0]                rsp_valid,
  output logic [AXI_DATA_WIDTH-1:0]         rsp_data,
  output logic                              rsp_err,
  rom_read_scheduler_if.master              m_axil
);

  localparam int unsigned IdxW      = idx_width(NUM_REQ);
  localparam int unsigned CntW      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit          TimeoutEn = (TIMEOUT_CYCLES > 0);
  localparam logic [CntW-1:0] CntMax  = '1;
  localparam logic [CntW-1:0] CntLast = CntW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_e                    state_q, state_d;
  logic [IdxW-1:0]           ptr_q, ptr_d;
  logic [IdxW-1:0]           owner_q, owner_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic [NUM_REQ-1:0]        rsp_valid_q, rsp_valid_d;
  logic [AXI_DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                      rsp_err_q, rsp_err_d;
  logic [NUM_REQ-1:0]        gnt;
  logic [IdxW-1:0]           gnt_idx;
  logic                      arvalid, rready, expired;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IdxW    (IdxW)
  ) u_arb (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx)
  );

  assign expired = TimeoutEn && (cnt_q == CntLast);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    req_ready   = '0;
    arvalid     = 1'b0;
    rready      = 1'b0;
    if ((state_q == StAddr || state_q == StData) && cnt_q != CntMax) begin
      cnt_d = cnt_q + 1'b1;
    end
    unique case (state_q)
      StIdle: begin
        // Gated by reset so no grant is visible while the block is held in reset.
        if (s_axi_rstn && |req_valid) begin
          req_ready = gnt;
          owner_d   = gnt_idx;
          addr_d    = req_addr[int'(gnt_idx)*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
          cnt_d     = '0;
          state_d   = StAddr;
          if (NUM_REQ == 1 || gnt_idx == IdxW'(NUM_REQ - 1)) ptr_d = '0;
          else                                               ptr_d = gnt_idx + 1'b1;
        end
      end
      StAddr: begin
        arvalid = 1'b1;
        if (expired) begin
          rsp_valid_d[owner_q] = 1'b1;
          rsp_data_d           = AXI_DATA_WIDTH'(TIMEOUT_DATA);
          rsp_err_d            = 1'b1;
          // An address accepted in the expiry cycle still owes its R beat.
          state_d              = m_axil.arready ? StDrainData : StDrainAddr;
        end else if (m_axil.arready) begin
          state_d = StData;
        end
      end
      StData: begin
        rready = 1'b1;
        if (m_axil.rvalid) begin
          rsp_valid_d[owner_q] = 1'b1;
          rsp_data_d           = m_axil.rdata;
          rsp_err_d            = (m_axil.rresp != AXI_RESP_OKAY);
          state_d              = StIdle;
        end else if (expired) begin
          rsp_valid_d[owner_q] = 1'b1;
          rsp_data_d           = AXI_DATA_WIDTH'(TIMEOUT_DATA);
          rsp_err_d            = 1'b1;
          state_d              = StDrainData;
        end
      end
      StDrainAddr: begin
        arvalid = 1'b1;
        if (m_axil.arready) state_d = StDrainData;
      end
      StDrainData: begin
        rready = 1'b1;
        if (m_axil.rvalid) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge s_axi_clk or negedge s_axi_rstn) begin
    if (!s_axi_rstn) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      owner_q     <= '0;
      addr_q      <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid      = rsp_valid_q;
  assign rsp_data       = rsp_data_q;
  assign rsp_err        = rsp_err_q;
  assign m_axil.araddr  = addr_q;
  assign m_axil.arprot  = 3'b000;
  assign m_axil.arvalid = arvalid;
  assign m_axil.rready  = rready;

endmodule

// File: tb/tb_rom_read_scheduler.sv
// Self-checking bench: cycle-timestamp reference model of the scheduler plus a
// programmable AXI-Lite target, directed scenarios followed by random traffic.
module tb_rom_read_scheduler;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned T  = 16;

  logic            clk  = 1'b0;
  logic            rstn = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*AW-1:0] req_addr  = '0;
  logic [N-1:0]    req_ready, rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic            rsp_err;

  always #5 clk = ~clk;

  rom_read_scheduler_if #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) axil ();

  rom_read_scheduler #(
    .NUM_REQ        (N),
    .AXI_ADDR_WIDTH (AW),
    .AXI_DATA_WIDTH (DW),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .s_axi_clk  (clk),
    .s_axi_rstn (rstn),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .m_axil     (axil)
  );

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;

  // Requesters
  bit          pend[N];
  logic [AW-1:0] raddr[N];
  // Reference model: one read in flight, tracked by cycle numbers
  int ptr;
  bit busy, ar_done, r_done, timed_out;
  int g_cyc, owner, ar_cnt, r_cnt, ar_dly, r_dly;
  logic [AW-1:0] cur_addr;
  logic [1:0]    cur_resp;
  logic [DW-1:0] cur_data;
  bit            exp_rsp, exp_err;
  int            exp_cyc, exp_owner;
  logic [DW-1:0] exp_data;
  // Scenario configuration
  bit            rnd_mode, hold_all, data_by_addr;
  int            cfg_ar, cfg_r;
  logic [1:0]    cfg_resp;
  logic [DW-1:0] cfg_data;
  // Observation logs
  int            gnt_log[$];
  int            gnt_cyc[$];
  int            rsp_seen;
  int            last_rsp_cyc;
  logic [DW-1:0] last_data;
  logic          last_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit any_pend();
    for (int i = 0; i < N; i++) if (pend[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int pick_delay();
    return ($urandom_range(0, 9) == 0) ? int'($urandom_range(10, 22)) : int'($urandom_range(0, 3));
  endfunction

  // One clock cycle: called at a negedge, returns at the next negedge.
  task automatic step();
    logic [N-1:0] exp_rdy, exp_vec;
    int  w;
    bit  ar_hs, r_hs;
    if (rsp_valid != '0) begin
      rsp_seen++;
      last_rsp_cyc = cyc;
      last_data    = rsp_data;
      last_err     = rsp_err;
    end
    if (exp_rsp && cyc == exp_cyc) begin
      exp_vec = '0;
      exp_vec[exp_owner] = 1'b1;
      check("rsp_valid", rsp_valid, exp_vec);
      check("rsp_data", rsp_data, exp_data);
      check("rsp_err", rsp_err, exp_err);
      exp_rsp = 1'b0;
    end else begin
      check("rsp_valid_quiet", rsp_valid, '0);
    end
    check("arvalid", axil.arvalid, busy && !ar_done);
    if (busy && !ar_done) check("araddr", axil.araddr, cur_addr);
    check("rready", axil.rready, busy && ar_done && !r_done);

    ar_hs = busy && !ar_done && ar_cnt >= ar_dly;
    r_hs  = busy && ar_done && !r_done && r_cnt >= r_dly;
    axil.arready = ar_hs;
    axil.rvalid  = r_hs;
    axil.rdata   = r_hs ? cur_data : DW'($urandom);
    axil.rresp   = r_hs ? cur_resp : 2'($urandom);
    for (int i = 0; i < N; i++) begin
      req_valid[i] = pend[i];
      req_addr[i*AW +: AW] = raddr[i];
    end
    exp_rdy = '0;
    w = -1;
    if (!busy) begin
      for (int k = 0; k < N; k++) begin
        if (w < 0 && pend[(ptr + k) % N]) w = (ptr + k) % N;
      end
    end
    if (w >= 0) exp_rdy[w] = 1'b1;
    #1;
    check("req_ready", req_ready, exp_rdy);

    if (busy) begin
      if (!timed_out && !r_hs && cyc == g_cyc + int'(T)) begin
        timed_out = 1'b1;
        exp_rsp   = 1'b1;
        exp_cyc   = cyc + 1;
        exp_owner = owner;
        exp_data  = 32'hDEAD_BEEF;
        exp_err   = 1'b1;
      end
      if (r_hs) begin
        r_done = 1'b1;
        busy   = 1'b0;
        if (!timed_out) begin
          exp_rsp   = 1'b1;
          exp_cyc   = cyc + 1;
          exp_owner = owner;
          exp_data  = cur_data;
          exp_err   = (cur_resp != 2'b00);
        end
      end else if (ar_done) begin
        r_cnt++;
      end
      if (ar_hs) begin
        ar_done = 1'b1;
        r_cnt   = 0;
      end else if (!ar_done) begin
        ar_cnt++;
      end
    end
    if (w >= 0) begin
      busy = 1'b1; g_cyc = cyc; owner = w; cur_addr = raddr[w];
      ar_done = 1'b0; r_done = 1'b0; timed_out = 1'b0; ar_cnt = 0; r_cnt = 0;
      if (rnd_mode) begin
        ar_dly   = pick_delay();
        r_dly    = pick_delay();
        cur_resp = 2'($urandom);
        cur_data = DW'($urandom);
      end else begin
        ar_dly   = cfg_ar;
        r_dly    = cfg_r;
        cur_resp = cfg_resp;
        cur_data = data_by_addr ? {16'hA5A5, raddr[w]} : cfg_data;
      end
      ptr = (w + 1) % N;
      gnt_log.push_back(w);
      gnt_cyc.push_back(cyc);
      if (!hold_all) pend[w] = 1'b0;
    end
    if (rnd_mode) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i]  = 1'b1;
          raddr[i] = AW'($urandom) & ~AW'(3);
        end
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain();
    int b = 0;
    while ((busy || exp_rsp || any_pend()) && b < 400) begin
      step();
      b++;
    end
    check("drain_bound", {62'd0, busy, exp_rsp}, 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready, '0);
    check({tag, "_rsp_valid"}, rsp_valid, '0);
    check({tag, "_rsp_data"}, rsp_data, '0);
    check({tag, "_rsp_err"}, rsp_err, 1'b0);
    check({tag, "_arvalid"}, axil.arvalid, 1'b0);
    check({tag, "_araddr"}, axil.araddr, '0);
    check({tag, "_arprot"}, axil.arprot, 3'b000);
    check({tag, "_rready"}, axil.rready, 1'b0);
  endtask

  // Asynchronous reset mid-cycle; model returns to its reset state.
  task automatic pulse_reset(input string tag);
    #2;
    req_valid = 4'b1100;
    rstn      = 1'b0;
    axil.arready = 1'b0;
    axil.rvalid  = 1'b0;
    #1;
    check_reset_outputs(tag);
    busy = 1'b0; exp_rsp = 1'b0; ptr = 0;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    req_valid = '0;
    rstn = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int b;
    int n0;
    for (int i = 0; i < N; i++) begin
      pend[i]  = 1'b0;
      raddr[i] = '0;
    end
    ptr = 0; busy = 1'b0; exp_rsp = 1'b0; rnd_mode = 1'b0; hold_all = 1'b0;
    data_by_addr = 1'b0; cfg_ar = 0; cfg_r = 0; cfg_resp = 2'b00; cfg_data = '0;
    rsp_seen = 0; last_rsp_cyc = 0; last_data = '0; last_err = 1'b0;
    axil.arready = 1'b0; axil.rvalid = 1'b0; axil.rdata = '0; axil.rresp = 2'b00;

    // Reset state, with requests present to confirm no grant leaks out
    req_valid = '1;
    @(negedge clk);
    check_reset_outputs("por");
    req_valid = '0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Single read against a zero-wait target
    cfg_data = 32'h0005_0001;
    pend[0] = 1'b1; raddr[0] = 16'h0000;
    gnt_cyc.delete();
    n0 = rsp_seen;
    drain();
    check("single_gnt_cycle", 64'(last_rsp_cyc - gnt_cyc[0]), 64'd3);
    check("single_data", last_data, 32'h0005_0001);
    check("single_rsp_count", 64'(rsp_seen - n0), 64'd1);

    // Round robin with all four requesters held valid
    pulse_reset("rst_a");
    hold_all = 1'b1; data_by_addr = 1'b1;
    for (int i = 0; i < N; i++) begin
      pend[i]  = 1'b1;
      raddr[i] = AW'(4 * i);
    end
    gnt_log.delete();
    b = 0;
    while (gnt_log.size() < 5 && b < 100) begin
      step();
      b++;
    end
    hold_all = 1'b0;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    drain();
    check("rr_count", 64'(gnt_log.size()), 64'd5);
    if (gnt_log.size() >= 5) begin
      check("rr_g0", 64'(gnt_log[0]), 64'd0);
      check("rr_g1", 64'(gnt_log[1]), 64'd1);
      check("rr_g2", 64'(gnt_log[2]), 64'd2);
      check("rr_g3", 64'(gnt_log[3]), 64'd3);
      check("rr_g4", 64'(gnt_log[4]), 64'd0);
    end
    data_by_addr = 1'b0;

    // Backpressure on both AR and R
    cfg_ar = 5; cfg_r = 3; cfg_data = 32'hCAFE_0010;
    pend[1] = 1'b1; raddr[1] = 16'h0010;
    n0 = rsp_seen;
    drain();
    check("bp_rsp_count", 64'(rsp_seen - n0), 64'd1);
    check("bp_data", last_data, 32'hCAFE_0010);

    // Slave error
    cfg_ar = 0; cfg_r = 0; cfg_resp = 2'b10; cfg_data = 32'h1234_5678;
    pend[2] = 1'b1; raddr[2] = 16'h0024;
    drain();
    check("slverr_err", last_err, 1'b1);
    check("slverr_data", last_data, 32'h1234_5678);
    cfg_resp = 2'b00;

    // Timeout with a second requester waiting
    cfg_r = 40; cfg_data = 32'h0BAD_0BAD;
    pend[0] = 1'b1; raddr[0] = 16'h0020;
    gnt_cyc.delete();
    n0 = rsp_seen;
    step();
    cfg_r = 0; cfg_data = 32'h0000_3333;
    pend[3] = 1'b1; raddr[3] = 16'h0030;
    b = 0;
    while (rsp_seen == n0 && b < 60) begin
      step();
      b++;
    end
    check("to_err", last_err, 1'b1);
    check("to_data", last_data, 32'hDEAD_BEEF);
    if (gnt_cyc.size() >= 1) check("to_pulse_cycle", 64'(last_rsp_cyc - gnt_cyc[0]), 64'd17);
    drain();
    check("to_gnt_count", 64'(gnt_cyc.size()), 64'd2);
    if (gnt_cyc.size() >= 2) check("to_second_gnt", 64'(gnt_cyc[1] - gnt_cyc[0]), 64'd43);
    check("to_after_data", last_data, 32'h0000_3333);
    check("to_rsp_count", 64'(rsp_seen - n0), 64'd2);

    // Reset while in DATA; rr pointer must restart at 0
    cfg_r = 10;
    pend[2] = 1'b1; raddr[2] = 16'h0040;
    b = 0;
    while (!(busy && ar_done) && b < 20) begin
      step();
      b++;
    end
    check("rst_in_data", {63'd0, busy && ar_done}, 64'd1);
    pulse_reset("rst_b");
    cfg_r = 0;
    pend[2] = 1'b1; raddr[2] = 16'h0050;
    pend[3] = 1'b1; raddr[3] = 16'h0060;
    gnt_log.delete();
    step();
    check("rst_first_gnt", 64'(gnt_log.size() > 0 ? gnt_log[0] : -1), 64'd2);
    drain();

    // Random traffic
    rnd_mode = 1'b1;
    repeat (1500) step();
    rnd_mode = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/rom_read_scheduler.md
# rom_read_scheduler

Shares one AXI-Lite read port of the system register ROM among NUM_REQ internal requesters (DMA channel engines, interrupt logic, debug) using round-robin arbitration. It serialises reads, one outstanding at a time, and returns each response to the requester that issued it. It bounds every read with a timeout so that a stalled target cannot hang a requester. It sits between the internal requesters and the AXI-Lite slave port of the ROM/register-file target. It drives the AR/R channels only. AW/W/B are not driven.

## Interface
- NUM_REQ, 4, number of requesters (≥1)
- AXI_ADDR_WIDTH, 16, read address width
- AXI_DATA_WIDTH, 32, read data width
- TIMEOUT_CYCLES, 256, cycles from grant before error response; 0 disables timeout
- s_axi_clk  input  1  single clock for all logic
- s_axi_rstn  input  1  asynchronous, active-low reset
- req_valid  input  NUM_REQ  bit i: requester i wants a read; held until req_ready[i]
- req_addr  input  NUM_REQ*AXI_ADDR_WIDTH  slice i = byte address of requester i
- req_ready  output  NUM_REQ  combinational one-hot grant; transfer on valid&ready
- rsp_valid  output  NUM_REQ  one-cycle pulse to the requester owning the response
- rsp_data  output  AXI_DATA_WIDTH  read data, valid with any rsp_valid bit
- rsp_err  output  1  1 = SLVERR/DECERR or timeout, valid with rsp_valid
- m_axil_araddr  output  AXI_ADDR_WIDTH  read address
- m_axil_arprot  output  3  constant 3'b000
- m_axil_arvalid  output  1  address valid
- m_axil_arready  input  1  address accepted
- m_axil_rdata  input  AXI_DATA_WIDTH  read data
- m_axil_rresp  input  2  read response
- m_axil_rvalid  input  1  read data valid
- m_axil_rready  output  1  read data accept

## Operation
- States: IDLE, ADDR, DATA, DRAIN_ADDR, DRAIN_DATA.
- IDLE:
  - If any req_valid is set, the winner is the first set bit searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - req_ready[winner]=1 in the same cycle.
  - On the edge: latch the address and owner index, set rr_ptr=(winner+1) mod NUM_REQ, clear the timeout counter, and go to ADDR.
- ADDR:
  - arvalid=1, with araddr stable.
  - On arvalid&arready, go to DATA.
- DATA:
  - rready=1.
  - On rvalid: register rsp_valid[owner], rsp_data=rdata and rsp_err=(rresp!=2'b00), then go to IDLE.
- Timeout:
  - The counter increments every ADDR/DATA cycle.
  - In the cycle where the count equals TIMEOUT_CYCLES-1 and no completing handshake occurs, register an error response: rsp_err=1, rsp_data=TIMEOUT_DATA (32'hDEAD_BEEF).
  - Then go to DRAIN_ADDR from ADDR, or to DRAIN_DATA from DATA.
  - A completing handshake in that same cycle wins over the timeout.
- DRAIN_ADDR / DRAIN_DATA:
  - Complete the AXI transaction silently: arvalid held until arready, then rready until rvalid.
  - Data is discarded, no rsp_valid is issued and no grants are made.
  - Then go to IDLE.
  - arvalid is never withdrawn before arready.
- No grant in any state other than IDLE. req_ready is all-zero outside IDLE.

## Timing
- Reset values: all outputs 0; state IDLE; rr_ptr 0; counter 0.
- Reset acts immediately and asynchronously in any state. An in-flight AXI read is abandoned; the target shares s_axi_rstn.
- Zero-wait target: grant cycle 0, arvalid cycle 1, rvalid cycle 2, rsp_valid cycle 3.
- Throughput: one read per 3 cycles. A new grant may coincide with the previous rsp_valid pulse.
- Timeout response pulse: cycle TIMEOUT_CYCLES+1 after the grant cycle.
- Counter width: $clog2(TIMEOUT_CYCLES+1). Saturates; never wraps.
- NUM_REQ=1: rr_ptr is constant 0.

## Structure
- Package rom_sched_pkg:
  - state enum
  - TIMEOUT_DATA
  - AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR constants
- Sub-module rr_arbiter:
  - inputs: request vector and pointer
  - outputs: one-hot grant and binary index
  - purely combinational; instanced once
- Top module: FSM, timeout counter, response registers.

## Test plan
- Single read:
  - Stimulus: req 0, addr 16'h0000, zero-wait target returning 32'h0005_0001.
  - Response: req_ready[0] in cycle 0, arvalid in cycle 1; rsp_valid[0] in cycle 3 with data 32'h0005_0001, err=0.
- Round-robin:
  - Stimulus: all four requesters held valid with addrs 0/4/8/C.
  - Response: grant order 0,1,2,3,0; each rsp_valid matches its owner and address.
- Backpressure:
  - Stimulus: arready delayed 5 cycles, rvalid delayed 3 cycles.
  - Response: arvalid/araddr stable throughout; rready held high; exactly one rsp_valid.
- Slave error:
  - Stimulus: rresp=2'b10, rdata=32'h1234_5678.
  - Response: rsp_err=1, rsp_data=32'h1234_5678.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=16, rvalid withheld for 40 cycles, a second requester waiting.
  - Response:
    - err pulse with 32'hDEAD_BEEF at grant+17;
    - no grant before the late rvalid handshake;
    - late data not reported;
    - second requester granted in the next IDLE.
- Reset mid-DATA:
  - Stimulus: deassert rstn while in DATA.
  - Response: all outputs 0 immediately. After release, with req 2 and req 3 pending, req 2 is granted first (rr_ptr=0).
